mem_arbiter: RTL and testbench

Two-requester memory arbiter sharing the single simulation/data-memory port between instruction fetch (IF, read-only) and the load/store stage (LS, read/write). It accepts at most one outstanding transaction. LS wins by default, and a starvation counter forces an IF grant after a bounded streak of LS grants. It sits between the pipeline front/LS stages and the memory model or bus bridge, and it aligns all addresses to 8 bytes.

---
 rtl/mem_arbiter.sv | 125 ++++++++++++
 tb/tb_mem_arbiter.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// Two-requester memory arbiter: instruction fetch (read-only) and load/store share
// one memory port, one transaction in flight, LS priority with an IF anti-starvation streak.
module mem_arbiter #(
  parameter int XLEN       = 64,
  parameter int STARVE_MAX = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            if_req,
  input  logic [XLEN-1:0] if_addr,
  output logic            if_gnt,
  output logic            if_rvalid,
  output logic [XLEN-1:0] if_rdata,
  input  logic            ls_req,
  input  logic            ls_we,
  input  logic [XLEN-1:0] ls_addr,
  input  logic [XLEN-1:0] ls_wdata,
  input  logic [7:0]      ls_wmask,
  output logic            ls_gnt,
  output logic            ls_rvalid,
  output logic [XLEN-1:0] ls_rdata,
  output logic            mem_req,
  output logic            mem_we,
  output logic [XLEN-1:0] mem_addr,
  output logic [XLEN-1:0] mem_wdata,
  output logic [7:0]      mem_wmask,
  input  logic            mem_ready,
  input  logic            mem_rvalid,
  input  logic [XLEN-1:0] mem_rdata,
  output logic            busy
);

  typedef enum logic [1:0] {IDLE, REQ, WAIT} state_t;

  localparam logic [3:0] STREAK_LIMIT = 4'(STARVE_MAX);

  state_t          state_reg, state_next;
  logic [3:0]      streak_reg;
  logic            owner_ls_reg;
  logic            we_reg;
  logic [XLEN-1:0] addr_reg;
  logic [XLEN-1:0] wdata_reg;
  logic [7:0]      wmask_reg;
  logic            if_rvalid_reg, ls_rvalid_reg;
  logic [XLEN-1:0] if_rdata_reg, ls_rdata_reg;
  logic            grant_if, grant_ls;
  logic [XLEN-1:0] sel_addr;

  always_comb begin
    state_next = state_reg;
    grant_if   = 1'b0;
    grant_ls   = 1'b0;
    case (state_reg)
      IDLE: begin
        // Grants are suppressed while reset is held so every output reads 0.
        if (!rst) begin
          grant_ls = ls_req && !(if_req && streak_reg == STREAK_LIMIT);
          grant_if = if_req && !grant_ls;
          if (grant_ls || grant_if) state_next = REQ;
        end
      end
      REQ:     if (mem_ready)  state_next = WAIT;
      WAIT:    if (mem_rvalid) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state_reg <= IDLE;
    else     state_reg <= state_next;
  end

  assign sel_addr = grant_ls ? ls_addr : if_addr;

  always_ff @(posedge clk) begin
    if (rst) begin
      streak_reg    <= 4'd0;
      owner_ls_reg  <= 1'b0;
      we_reg        <= 1'b0;
      addr_reg      <= '0;
      wdata_reg     <= '0;
      wmask_reg     <= 8'h00;
      if_rvalid_reg <= 1'b0;
      ls_rvalid_reg <= 1'b0;
      if_rdata_reg  <= '0;
      ls_rdata_reg  <= '0;
    end else begin
      if_rvalid_reg <= 1'b0;
      ls_rvalid_reg <= 1'b0;
      if (grant_if || grant_ls) begin
        owner_ls_reg <= grant_ls;
        we_reg       <= grant_ls && ls_we;
        addr_reg     <= {sel_addr[XLEN-1:3], 3'b000};
        wdata_reg    <= (grant_ls && ls_we) ? ls_wdata : '0;
        wmask_reg    <= (grant_ls && ls_we) ? ls_wmask : 8'h00;
        // Streak only grows while IF is actually being passed over.
        if (grant_if || !if_req)            streak_reg <= 4'd0;
        else if (streak_reg != STREAK_LIMIT) streak_reg <= streak_reg + 4'd1;
      end
      if (state_reg == WAIT && mem_rvalid) begin
        if (owner_ls_reg) begin
          ls_rvalid_reg <= 1'b1;
          ls_rdata_reg  <= we_reg ? '0 : mem_rdata;
        end else begin
          if_rvalid_reg <= 1'b1;
          if_rdata_reg  <= mem_rdata;
        end
      end
    end
  end

  assign if_gnt    = grant_if;
  assign ls_gnt    = grant_ls;
  assign if_rvalid = if_rvalid_reg;
  assign if_rdata  = if_rdata_reg;
  assign ls_rvalid = ls_rvalid_reg;
  assign ls_rdata  = ls_rdata_reg;
  assign mem_req   = (state_reg == REQ);
  assign mem_we    = we_reg;
  assign mem_addr  = addr_reg;
  assign mem_wdata = wdata_reg;
  assign mem_wmask = wmask_reg;
  assign busy      = (state_reg != IDLE);

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed scenarios plus random traffic, all checked cycle by
// cycle against a transaction-level model with its own reference memory.
module tb_mem_arbiter;
  localparam int XLEN       = 64;
  localparam int STARVE_MAX = 4;

  logic            clk;
  logic            rst;
  logic            if_req, if_gnt, if_rvalid;
  logic [XLEN-1:0] if_addr, if_rdata;
  logic            ls_req, ls_we, ls_gnt, ls_rvalid;
  logic [XLEN-1:0] ls_addr, ls_wdata, ls_rdata;
  logic [7:0]      ls_wmask;
  logic            mem_req, mem_we, mem_ready, mem_rvalid, busy;
  logic [XLEN-1:0] mem_addr, mem_wdata, mem_rdata;
  logic [7:0]      mem_wmask;

  mem_arbiter #(.XLEN(XLEN), .STARVE_MAX(STARVE_MAX)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_rvalid(if_rvalid), .if_rdata(if_rdata),
    .ls_req(ls_req), .ls_we(ls_we), .ls_addr(ls_addr), .ls_wdata(ls_wdata), .ls_wmask(ls_wmask),
    .ls_gnt(ls_gnt), .ls_rvalid(ls_rvalid), .ls_rdata(ls_rdata),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_wmask(mem_wmask), .mem_ready(mem_ready), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
    .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  // Memory contents as seen by the responder and by the reference model.
  logic [63:0] slv_mem [32];
  logic [63:0] ref_mem [32];
  logic [4:0]  slv_idx;

  // Transaction-level model: phase 0 = free, 1 = request issued, 2 = awaiting data.
  int          m_phase, m_streak, m_cnt;
  logic        m_owner_ls, m_we;
  logic [63:0] m_addr, m_wdata, m_exp;
  logic [7:0]  m_mask;
  logic        m_rv_if, m_rv_ls;
  logic [63:0] m_if_rdata, m_ls_rdata;

  int   p_if, p_ls, p_we, p_ready, p_rvalid, p_spur, ready_delay;
  logic hold_rvalid, if_granted, ls_granted, rec;
  bit   gq[$];
  int   mreq_cnt, rv_seen;

  function automatic logic [63:0] rand64();
    return {$urandom, $urandom};
  endfunction

  function automatic logic [63:0] rand_addr();
    return 64'h8000_0000 + 64'($urandom_range(0, 255));
  endfunction

  task automatic drive();
    if (if_granted) begin if_req = 1'b0; if_granted = 1'b0; end
    if (ls_granted) begin ls_req = 1'b0; ls_granted = 1'b0; end
    if (!if_req && $urandom_range(1, 100) <= p_if) begin
      if_req  = 1'b1;
      if_addr = rand_addr();
    end
    if (!ls_req && $urandom_range(1, 100) <= p_ls) begin
      ls_req   = 1'b1;
      ls_we    = ($urandom_range(1, 100) <= p_we);
      ls_addr  = rand_addr();
      ls_wdata = rand64();
      ls_wmask = 8'($urandom);
    end
    mem_ready  = 1'b0;
    mem_rvalid = 1'b0;
    mem_rdata  = rand64();
    if (m_phase == 1) begin
      mem_ready = (ready_delay < 0) ? ($urandom_range(1, 100) <= p_ready) : (m_cnt >= ready_delay);
      if ($urandom_range(1, 100) <= p_spur) mem_rvalid = 1'b1;
    end
    if (m_phase == 2 && !hold_rvalid && $urandom_range(1, 100) <= p_rvalid) begin
      mem_rvalid = 1'b1;
      mem_rdata  = slv_mem[slv_idx];
    end
  endtask

  task automatic eval();
    logic eg_ls, eg_if;
    logic [63:0] a;
    int idx;
    eg_ls = !rst && m_phase == 0 && ls_req && !(if_req && m_streak == STARVE_MAX);
    eg_if = !rst && m_phase == 0 && if_req && !eg_ls;
    check_val("if_gnt", 64'(if_gnt), 64'(eg_if));
    check_val("ls_gnt", 64'(ls_gnt), 64'(eg_ls));
    check_val("busy", 64'(busy), 64'(m_phase != 0));
    check_val("mem_req", 64'(mem_req), 64'(m_phase == 1));
    if (m_phase == 1) begin
      check_val("mem_addr", mem_addr, m_addr);
      check_val("mem_we", 64'(mem_we), 64'(m_we));
      check_val("mem_wmask", 64'(mem_wmask), 64'(m_mask));
      if (m_we) check_val("mem_wdata", mem_wdata, m_wdata);
    end
    check_val("if_rvalid", 64'(if_rvalid), 64'(m_rv_if));
    check_val("ls_rvalid", 64'(ls_rvalid), 64'(m_rv_ls));
    check_val("if_rdata", if_rdata, m_if_rdata);
    check_val("ls_rdata", ls_rdata, m_ls_rdata);
    if (rec && if_gnt) gq.push_back(1'b0);
    if (rec && ls_gnt) gq.push_back(1'b1);
    if (mem_req) mreq_cnt++;
    if (if_rvalid || ls_rvalid) rv_seen++;
    // Responder: capture accepted address, apply writes.
    if (mem_req && mem_ready) begin
      slv_idx = mem_addr[7:3];
      if (mem_we)
        for (int b = 0; b < 8; b++)
          if (mem_wmask[b]) slv_mem[slv_idx][8*b +: 8] = mem_wdata[8*b +: 8];
    end
    // Model state for the next cycle.
    if (rst) begin
      m_phase = 0; m_streak = 0; m_rv_if = 1'b0; m_rv_ls = 1'b0;
      m_if_rdata = '0; m_ls_rdata = '0;
    end else begin
      m_rv_if = 1'b0;
      m_rv_ls = 1'b0;
      case (m_phase)
        0: if (eg_ls || eg_if) begin
          a          = eg_ls ? ls_addr : if_addr;
          m_owner_ls = eg_ls;
          m_addr     = a & ~64'h7;
          m_we       = eg_ls && ls_we;
          m_mask     = m_we ? ls_wmask : 8'h00;
          m_wdata    = ls_wdata;
          idx        = int'(m_addr[7:3]);
          if (m_we) begin
            for (int b = 0; b < 8; b++)
              if (m_mask[b]) ref_mem[idx][8*b +: 8] = m_wdata[8*b +: 8];
            m_exp = '0;
          end else begin
            m_exp = ref_mem[idx];
          end
          if (eg_if || !if_req) m_streak = 0;
          else m_streak = (m_streak + 1 > STARVE_MAX) ? STARVE_MAX : m_streak + 1;
          if_granted = eg_if;
          ls_granted = eg_ls;
          m_phase = 1;
          m_cnt   = 0;
        end
        1: if (mem_ready) m_phase = 2; else m_cnt++;
        default: if (mem_rvalid) begin
          if (m_owner_ls) begin m_rv_ls = 1'b1; m_ls_rdata = m_exp; end
          else            begin m_rv_if = 1'b1; m_if_rdata = m_exp; end
          m_phase = 0;
        end
      endcase
    end
  endtask

  task automatic cycle();
    @(negedge clk);
    eval();
    @(posedge clk);
    #1;
    drive();
  endtask

  task automatic drain();
    p_if = 0; p_ls = 0; p_spur = 0; ready_delay = 0; p_rvalid = 100; hold_rvalid = 1'b0;
    repeat (12) cycle();
  endtask

  logic [63:0] v, exp6;

  initial begin
    rst = 1'b1;
    if_req = 1'b0; if_addr = '0;
    ls_req = 1'b0; ls_we = 1'b0; ls_addr = '0; ls_wdata = '0; ls_wmask = 8'h00;
    mem_ready = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;
    m_phase = 0; m_streak = 0; m_cnt = 0; m_owner_ls = 1'b0; m_we = 1'b0;
    m_addr = '0; m_wdata = '0; m_exp = '0; m_mask = 8'h00;
    m_rv_if = 1'b0; m_rv_ls = 1'b0; m_if_rdata = '0; m_ls_rdata = '0;
    p_if = 0; p_ls = 0; p_we = 0; p_ready = 100; p_rvalid = 100; p_spur = 0; ready_delay = 0;
    hold_rvalid = 1'b0; if_granted = 1'b0; ls_granted = 1'b0; rec = 1'b0;
    mreq_cnt = 0; rv_seen = 0; slv_idx = '0;
    for (int i = 0; i < 32; i++) begin
      v = rand64();
      slv_mem[i] = v;
      ref_mem[i] = v;
    end
    slv_mem[0] = 64'h1122334455667788;
    ref_mem[0] = 64'h1122334455667788;

    // Reset state
    repeat (3) cycle();
    check_val("rst_busy", 64'(busy), 64'd0);
    check_val("rst_mem_addr", mem_addr, 64'd0);
    check_val("rst_mem_wmask", 64'(mem_wmask), 64'd0);
    check_val("rst_if_rdata", if_rdata, 64'd0);
    rst = 1'b0;
    cycle();

    // Single IF read, single-cycle memory
    if_req = 1'b1; if_addr = 64'h8000_0004;
    rv_seen = 0;
    repeat (5) cycle();
    check_val("t1_if_rdata", if_rdata, 64'h1122334455667788);
    check_val("t1_rv_count", 64'(rv_seen), 64'd1);

    // LS write, ready held off three cycles
    ready_delay = 3;
    ls_req = 1'b1; ls_we = 1'b1; ls_addr = 64'h8000_0013; ls_wmask = 8'h08; ls_wdata = 64'hAB000000;
    mreq_cnt = 0;
    repeat (8) cycle();
    check_val("t2_mem_req_cycles", 64'(mreq_cnt), 64'd4);
    check_val("t2_ls_rdata", ls_rdata, 64'd0);
    check_val("t2_mem_byte3", 64'(slv_mem[2][31:24]), 64'hAB);
    drain();

    // Both requesters saturated: starvation release
    p_if = 100; p_ls = 100; p_we = 50; ready_delay = 0;
    gq.delete(); rec = 1'b1;
    repeat (19) cycle();
    rec = 1'b0;
    check_val("t3_grant_count", 64'(gq.size() >= 6), 64'd1);
    if (gq.size() >= 6) begin
      check_val("t3_g0", 64'(gq[0]), 64'd1);
      check_val("t3_g1", 64'(gq[1]), 64'd1);
      check_val("t3_g2", 64'(gq[2]), 64'd1);
      check_val("t3_g3", 64'(gq[3]), 64'd1);
      check_val("t3_g4", 64'(gq[4]), 64'd0);
      check_val("t3_g5", 64'(gq[5]), 64'd1);
    end
    drain();

    // LS-only traffic, then a lone IF request must win at once
    p_ls = 100; p_we = 50;
    repeat (9) cycle();
    drain();
    if_req = 1'b1; if_addr = rand_addr();
    gq.delete(); rec = 1'b1;
    cycle();
    rec = 1'b0;
    check_val("t4_grants", 64'(gq.size()), 64'd1);
    if (gq.size() == 1) check_val("t4_is_if", 64'(gq[0]), 64'd0);
    drain();

    // Reset while waiting for read data drops the transaction
    hold_rvalid = 1'b1;
    if_req = 1'b1; if_addr = rand_addr();
    repeat (3) cycle();
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    check_val("t5_busy", 64'(busy), 64'd0);
    check_val("t5_mem_req", 64'(mem_req), 64'd0);
    check_val("t5_mem_addr", mem_addr, 64'd0);
    check_val("t5_if_rdata", if_rdata, 64'd0);
    rv_seen = 0;
    mem_rvalid = 1'b1; mem_rdata = rand64();
    cycle();
    hold_rvalid = 1'b0;
    repeat (3) cycle();
    check_val("t5_no_rvalid", 64'(rv_seen), 64'd0);
    drain();

    // Spurious mem_rvalid during REQ is ignored
    p_spur = 100; ready_delay = 2;
    ls_req = 1'b1; ls_we = 1'b0; ls_addr = 64'h8000_0028; ls_wmask = 8'hFF;
    exp6 = ref_mem[5];
    rv_seen = 0;
    repeat (8) cycle();
    check_val("t6_ls_rdata", ls_rdata, exp6);
    check_val("t6_rv_count", 64'(rv_seen), 64'd1);
    drain();

    // Random mixed traffic
    p_if = 40; p_ls = 50; p_we = 50; p_ready = 60; p_rvalid = 50; p_spur = 20; ready_delay = -1;
    repeat (1500) cycle();
    p_ready = 100;
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
